network_input_process_rx: RTL and testbench

- Receive-side counterpart of the per-port output process.
- Accepts a GMII receive byte stream, strips the preamble and SFD, and packs frame bytes into 134-bit packet-buffer words.
- Writes those words into a buffer prefetched from the buffer-id pool.
- Issues one descriptor (bufid, length) per good frame toward the forwarding stage; one instance per network port.

---
 rtl/network_input_process_rx_pkg.sv | 34 +++
 rtl/network_input_process_rx_if.sv | 42 ++++
 rtl/network_input_process_rx_packer.sv | 59 +++++
 rtl/network_input_process_rx.sv | 140 ++++++++++++++
 tb/tb_network_input_process_rx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/network_input_process_rx_pkg.sv
// Shared packet-buffer word layout, GMII framing bytes and address widths.
// Pure definitions: no latency, no flow control.
package tsn_pkt_pkg;

  localparam int BUFID_W = 9;
  localparam int WADDR_W = 16;
  localparam int IDX_W   = WADDR_W - BUFID_W;
  localparam int LEN_W   = 11;
  localparam int DATA_W  = 128;
  localparam int WORD_W  = 134;

  localparam int FIRST_BIT = 133;
  localparam int LAST_BIT  = 132;
  localparam int INV_MSB   = 131;
  localparam int INV_LSB   = 128;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef logic [WORD_W-1:0] pkt_word_t;

  function automatic pkt_word_t make_word(input logic first, input logic last,
                                          input logic [3:0] inv,
                                          input logic [DATA_W-1:0] data);
    pkt_word_t w;
    w                  = '0;
    w[FIRST_BIT]       = first;
    w[LAST_BIT]        = last;
    w[INV_MSB:INV_LSB] = inv;
    w[DATA_W-1:0]      = data;
    return w;
  endfunction

endpackage

// File: rtl/network_input_process_rx_if.sv
// GMII receive, bufid grant, buffer write and descriptor signals of one rx port.
// master = the rx process, slave = its environment (PHY, pool, buffer, forwarding).
interface network_input_process_rx_if;
  import tsn_pkt_pkg::*;

  logic [7:0]         iv_gmii_rxd;
  logic               i_gmii_rx_dv;
  logic               i_gmii_rx_er;

  logic               o_pkt_bufid_rd;
  logic [BUFID_W-1:0] iv_pkt_bufid;
  logic               i_pkt_bufid_ack;

  pkt_word_t          ov_pkt_wdata;
  logic [WADDR_W-1:0] ov_pkt_waddr;
  logic               o_pkt_wr;

  logic [BUFID_W-1:0] ov_bufid;
  logic [LEN_W-1:0]   ov_pkt_len;
  logic               o_descriptor_wr;
  logic               i_descriptor_ack;

  logic               o_pkt_input_pulse;
  logic               o_pkt_drop_pulse;

  modport master (
    input  iv_gmii_rxd, i_gmii_rx_dv, i_gmii_rx_er,
    input  iv_pkt_bufid, i_pkt_bufid_ack, i_descriptor_ack,
    output o_pkt_bufid_rd, ov_pkt_wdata, ov_pkt_waddr, o_pkt_wr,
    output ov_bufid, ov_pkt_len, o_descriptor_wr,
    output o_pkt_input_pulse, o_pkt_drop_pulse
  );

  modport slave (
    output iv_gmii_rxd, i_gmii_rx_dv, i_gmii_rx_er,
    output iv_pkt_bufid, i_pkt_bufid_ack, i_descriptor_ack,
    input  o_pkt_bufid_rd, ov_pkt_wdata, ov_pkt_waddr, o_pkt_wr,
    input  ov_bufid, ov_pkt_len, o_descriptor_wr,
    input  o_pkt_input_pulse, o_pkt_drop_pulse
  );

endinterface

// File: rtl/network_input_process_rx_packer.sv
// Packs frame bytes into 16-byte buffer words; a word is written the cycle after its 16th byte.
// No backpressure: the buffer write port always accepts one word per cycle.
module rx_byte_packer
  import tsn_pkt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               shift,
  input  logic               flush,
  input  logic [7:0]         byte_dat,
  input  logic [BUFID_W-1:0] bufid,
  output pkt_word_t          wdata,
  output logic [WADDR_W-1:0] waddr,
  output logic               wr,
  output logic [LEN_W-1:0]   byte_cnt
);

  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic              word_full;
  logic [3:0]        inv_cnt;

  // Empty byte lanes of the last word; zero when the count is a multiple of 16.
  assign inv_cnt = 4'd0 - byte_cnt[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      word_full <= 1'b0;
      byte_cnt  <= '0;
      wdata     <= '0;
      waddr     <= '0;
      wr        <= 1'b0;
    end else begin
      wr <= 1'b0;
      if (start) begin
        byte_cnt  <= '0;
        idx       <= '0;
        word_full <= 1'b0;
      end else begin
        word_full <= shift && (byte_cnt[3:0] == 4'hF);
        if (shift) begin
          acc      <= {acc[DATA_W-9:0], byte_dat};
          byte_cnt <= byte_cnt + 1'b1;
        end
        // A full word pending at end of frame is emitted once, already marked last.
        if (word_full || flush) begin
          wr    <= 1'b1;
          waddr <= {bufid, idx};
          idx   <= idx + 1'b1;
          wdata <= make_word(idx == '0, flush, inv_cnt, acc << {inv_cnt, 3'b000});
        end
      end
    end
  end

endmodule

// File: rtl/network_input_process_rx.sv
// GMII rx port: strips preamble/SFD, writes frame words into a prefetched buffer, issues one descriptor per good frame.
// SFD to first word write 17 cycles; descriptor held until ack, frames arriving meanwhile are dropped.
module network_input_process_rx
  import tsn_pkt_pkg::*;
#(
  parameter int MAX_BYTES = 1536,
  parameter int MIN_BYTES = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  network_input_process_rx_if.master  rx
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_DESC = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  logic [2:0]         state;
  logic               held;
  logic [BUFID_W-1:0] bufid;
  logic               desc_arm;
  logic               skip_frame;
  logic [LEN_W-1:0]   byte_cnt;
  logic               desc_busy;
  logic               in_data;
  logic               too_long;
  logic               shift;
  logic               flush;
  logic               start;

  assign desc_busy = desc_arm | rx.o_descriptor_wr;
  assign in_data   = (state == ST_DATA);
  assign too_long  = (byte_cnt == LEN_W'(MAX_BYTES));
  assign shift     = in_data && rx.i_gmii_rx_dv && !rx.i_gmii_rx_er && !too_long;
  assign flush     = in_data && !rx.i_gmii_rx_dv && (byte_cnt >= LEN_W'(MIN_BYTES));
  assign start     = (state == ST_PRE) && rx.i_gmii_rx_dv && (rx.iv_gmii_rxd == SFD_BYTE)
                     && held && !desc_busy;

  // Bufid prefetch: keep requesting until one is held; it is consumed only by an acked descriptor.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx.o_pkt_bufid_rd <= 1'b0;
      held              <= 1'b0;
      bufid             <= '0;
    end else begin
      if (rx.o_descriptor_wr && rx.i_descriptor_ack) begin
        held <= 1'b0;
      end
      if (rx.o_pkt_bufid_rd && rx.i_pkt_bufid_ack) begin
        rx.o_pkt_bufid_rd <= 1'b0;
        held              <= 1'b1;
        bufid             <= rx.iv_pkt_bufid;
      end else begin
        rx.o_pkt_bufid_rd <= !held;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= ST_IDLE;
      skip_frame           <= 1'b1;
      desc_arm             <= 1'b0;
      rx.o_descriptor_wr   <= 1'b0;
      rx.ov_bufid          <= '0;
      rx.ov_pkt_len        <= '0;
      rx.o_pkt_input_pulse <= 1'b0;
      rx.o_pkt_drop_pulse  <= 1'b0;
    end else begin
      rx.o_pkt_input_pulse <= 1'b0;
      rx.o_pkt_drop_pulse  <= 1'b0;
      desc_arm             <= 1'b0;
      // After a reset, a frame already on the line is ignored until rx_dv drops.
      if (!rx.i_gmii_rx_dv) begin
        skip_frame <= 1'b0;
      end

      if (desc_arm) begin
        rx.o_descriptor_wr <= 1'b1;
        rx.ov_bufid        <= bufid;
        rx.ov_pkt_len      <= byte_cnt;
      end else if (rx.o_descriptor_wr && rx.i_descriptor_ack) begin
        rx.o_descriptor_wr   <= 1'b0;
        rx.o_pkt_input_pulse <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (rx.i_gmii_rx_dv && !skip_frame) state <= ST_PRE;
        end
        ST_PRE: begin
          if (!rx.i_gmii_rx_dv)                   state <= ST_IDLE;
          else if (rx.iv_gmii_rxd == SFD_BYTE)    state <= start ? ST_DATA : ST_DROP;
          else if (rx.iv_gmii_rxd != PREAMBLE_BYTE) state <= ST_DROP;
        end
        ST_DATA: begin
          if (!rx.i_gmii_rx_dv) begin
            if (flush) begin
              desc_arm <= 1'b1;
              state    <= ST_DESC;
            end else begin
              rx.o_pkt_drop_pulse <= 1'b1;
              state               <= ST_IDLE;
            end
          end else if (!shift) begin
            state <= ST_DROP;
          end
        end
        ST_DESC: begin
          if (rx.i_gmii_rx_dv)                                    state <= ST_PRE;
          else if (rx.o_descriptor_wr && rx.i_descriptor_ack)     state <= ST_IDLE;
        end
        ST_DROP: begin
          if (!rx.i_gmii_rx_dv) begin
            rx.o_pkt_drop_pulse <= 1'b1;
            state               <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rx_byte_packer u_packer (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (start),
    .shift    (shift),
    .flush    (flush),
    .byte_dat (rx.iv_gmii_rxd),
    .bufid    (bufid),
    .wdata    (rx.ov_pkt_wdata),
    .waddr    (rx.ov_pkt_waddr),
    .wr       (rx.o_pkt_wr),
    .byte_cnt (byte_cnt)
  );

endmodule

// File: tb/tb_network_input_process_rx.sv
// Random-payload frames against a frame-level reference: expected words, descriptor and pulse counts.
module tb_network_input_process_rx;
  import tsn_pkt_pkg::*;

  localparam int MIN_B = 64;
  localparam int MAX_B = 1536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  network_input_process_rx_if bus ();

  network_input_process_rx #(.MAX_BYTES(MAX_B), .MIN_BYTES(MIN_B)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .rx    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0]  addr;
    logic [133:0] dat;
    int           c;
  } wr_rec_t;

  wr_rec_t    wlog[$];
  logic [7:0] frame[$];
  int         drops = 0, inputs = 0, desc_glitch = 0, desc_cyc = 0;
  logic       prev_desc = 1'b0;
  logic [8:0] prev_bufid = '0;
  logic [10:0] prev_len = '0;

  // Reference state: which bufid the port should hold and the running pulse totals.
  logic       m_held = 1'b0;
  logic [8:0] m_bufid = '0;
  int         exp_drops = 0, exp_inputs = 0;
  int         sfd_cyc = 0, fall_cyc = 0;

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_pkt_wr) wlog.push_back('{addr: bus.ov_pkt_waddr, dat: bus.ov_pkt_wdata, c: cyc});
    if (bus.o_pkt_drop_pulse) drops++;
    if (bus.o_pkt_input_pulse) inputs++;
    if (bus.o_descriptor_wr && !prev_desc) desc_cyc = cyc;
    if (prev_desc && bus.o_descriptor_wr &&
        (bus.ov_bufid !== prev_bufid || bus.ov_pkt_len !== prev_len)) desc_glitch++;
    prev_desc  = bus.o_descriptor_wr;
    prev_bufid = bus.ov_bufid;
    prev_len   = bus.ov_pkt_len;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wr"},     bus.o_pkt_wr, 0);
    chk({tag, "_wdata"},  bus.ov_pkt_wdata, 0);
    chk({tag, "_waddr"},  bus.ov_pkt_waddr, 0);
    chk({tag, "_rd"},     bus.o_pkt_bufid_rd, 0);
    chk({tag, "_desc"},   bus.o_descriptor_wr, 0);
    chk({tag, "_bufid"},  bus.ov_bufid, 0);
    chk({tag, "_len"},    bus.ov_pkt_len, 0);
    chk({tag, "_inp"},    bus.o_pkt_input_pulse, 0);
    chk({tag, "_drp"},    bus.o_pkt_drop_pulse, 0);
  endtask

  task automatic grant(input logic [8:0] id);
    int n = 0;
    while (!bus.o_pkt_bufid_rd && n < 50) begin
      tick();
      n++;
    end
    chk("bufid_rd_seen", bus.o_pkt_bufid_rd, 1);
    bus.iv_pkt_bufid    = id;
    bus.i_pkt_bufid_ack = 1'b1;
    tick();
    bus.i_pkt_bufid_ack = 1'b0;
    bus.iv_pkt_bufid    = 9'($urandom);
    chk("bufid_rd_release", bus.o_pkt_bufid_rd, 0);
    m_held  = 1'b1;
    m_bufid = id;
  endtask

  task automatic send_frame(input int len, input int er_at, input int rst_at, input int sfd_grant);
    frame.delete();
    wlog.delete();
    for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
    bus.i_gmii_rx_dv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.iv_gmii_rxd = 8'h55;
      tick();
    end
    bus.iv_gmii_rxd = 8'hD5;
    if (sfd_grant >= 0) begin
      bus.iv_pkt_bufid    = 9'(sfd_grant);
      bus.i_pkt_bufid_ack = 1'b1;
    end
    sfd_cyc = cyc;
    tick();
    bus.i_pkt_bufid_ack = 1'b0;
    for (int i = 0; i < len; i++) begin
      bus.iv_gmii_rxd  = frame[i];
      bus.i_gmii_rx_er = (i == er_at);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk_quiet("mid_rst");
      end
      tick();
      rst = 1'b0;
      bus.i_gmii_rx_er = 1'b0;
    end
    bus.i_gmii_rx_dv = 1'b0;
    bus.iv_gmii_rxd  = 8'h00;
    fall_cyc = cyc;
    repeat (12) tick();
  endtask

  // Word k of the current frame: bytes laid out MSB-first, unused lanes zero.
  function automatic logic [133:0] exp_word(input int k, input int n);
    logic [127:0] d = '0;
    int pad = n * 16 - frame.size();
    for (int b = 0; b < 16; b++)
      if (16 * k + b < frame.size()) d[127 - 8 * b -: 8] = frame[16 * k + b];
    return {(k == 0), (k == n - 1), (k == n - 1) ? 4'(pad) : 4'd0, d};
  endfunction

  task automatic check_frame(input string tag);
    int n = (frame.size() + 15) / 16;
    int w = 0;
    logic [15:0] ea;
    while (!bus.o_descriptor_wr && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_desc_vld"}, bus.o_descriptor_wr, 1);
    chk({tag, "_desc_bufid"}, bus.ov_bufid, m_bufid);
    chk({tag, "_desc_len"}, bus.ov_pkt_len, frame.size());
    chk({tag, "_nwords"}, wlog.size(), n);
    for (int k = 0; k < n && k < wlog.size(); k++) begin
      ea = 16'(m_bufid) * 16'd128 + 16'(k);
      chk({tag, "_addr"}, wlog[k].addr, ea);
      chk({tag, "_word"}, wlog[k].dat, exp_word(k, n));
    end
    if (wlog.size() > 0) begin
      chk({tag, "_sfd_lat"}, wlog[0].c - (sfd_cyc + 1), 17);
      chk({tag, "_desc_after_last"}, desc_cyc - wlog[wlog.size() - 1].c, 1);
    end
    chk({tag, "_fall_lat_le2"}, (desc_cyc - (fall_cyc + 1)) <= 2, 1);
  endtask

  task automatic ack_desc(input string tag);
    bus.i_descriptor_ack = 1'b1;
    tick();
    bus.i_descriptor_ack = 1'b0;
    tick();
    exp_inputs++;
    m_held = 1'b0;
    chk({tag, "_desc_clr"}, bus.o_descriptor_wr, 0);
    chk({tag, "_inputs"}, inputs, exp_inputs);
  endtask

  task automatic expect_drop(input string tag, input logic desc_exp);
    exp_drops++;
    chk({tag, "_drops"}, drops, exp_drops);
    chk({tag, "_desc"}, bus.o_descriptor_wr, desc_exp);
    chk({tag, "_inputs"}, inputs, exp_inputs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int len, er, len1;
    bus.iv_gmii_rxd      = '0;
    bus.i_gmii_rx_dv     = 1'b0;
    bus.i_gmii_rx_er     = 1'b0;
    bus.iv_pkt_bufid     = '0;
    bus.i_pkt_bufid_ack  = 1'b0;
    bus.i_descriptor_ack = 1'b0;
    repeat (3) tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();
    tick();
    chk("rd_after_reset", bus.o_pkt_bufid_rd, 1);

    // Minimum length, exact multiple of 16, bufid 5.
    grant(9'h05);
    send_frame(64, -1, -1, -1);
    check_frame("f64");
    ack_desc("f64");

    grant(9'($urandom));
    send_frame(65, -1, -1, -1);
    check_frame("f65");
    ack_desc("f65");

    // rx_er drop; the held bufid carries over to the next frame.
    grant(9'($urandom));
    send_frame(80, 30, -1, -1);
    expect_drop("er30", 0);
    chk("er30_bufid_kept", bus.o_pkt_bufid_rd, 0);
    send_frame(100, -1, -1, -1);
    check_frame("f100");
    ack_desc("f100");

    // Length limits.
    grant(9'($urandom));
    send_frame(60, -1, -1, -1);
    expect_drop("runt", 0);
    send_frame(1537, -1, -1, -1);
    expect_drop("oversize", 0);
    chk("limits_bufid_kept", bus.o_pkt_bufid_rd, 0);
    send_frame(1536, -1, -1, -1);
    check_frame("fmax");
    ack_desc("fmax");

    // Descriptor ack withheld while a second frame arrives.
    grant(9'($urandom));
    len1 = $urandom_range(64, 200);
    send_frame(len1, -1, -1, -1);
    check_frame("held1");
    send_frame(70, -1, -1, -1);
    expect_drop("held2", 1);
    chk("held2_nowr", wlog.size(), 0);
    chk("held_len", bus.ov_pkt_len, len1);
    chk("held_bufid", bus.ov_bufid, m_bufid);
    while (cyc - desc_cyc < 200) tick();
    chk("held_still", bus.o_descriptor_wr, 1);
    ack_desc("held");

    // Bufid grant in the same cycle as SFD: frame drops, bufid is kept for the next one.
    len = $urandom_range(1, 500);
    send_frame(70, -1, -1, len);
    expect_drop("sfd_grant", 0);
    m_held  = 1'b1;
    m_bufid = 9'(len);
    chk("sfd_grant_rd", bus.o_pkt_bufid_rd, 0);
    send_frame(90, -1, -1, -1);
    check_frame("after_sfd_grant");
    ack_desc("after_sfd_grant");

    // Reset in the middle of a frame.
    grant(9'($urandom));
    send_frame(120, -1, 40, -1);
    m_held = 1'b0;
    chk("rst_no_drop", drops, exp_drops);
    chk("rst_no_desc", bus.o_descriptor_wr, 0);
    chk("rst_rd", bus.o_pkt_bufid_rd, 1);
    grant(9'($urandom));
    send_frame(100, -1, -1, -1);
    check_frame("after_rst");
    ack_desc("after_rst");

    for (int f = 0; f < 6; f++) begin
      if (!m_held) grant(9'($urandom));
      len = $urandom_range(40, 300);
      er  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      send_frame(len, er, -1, -1);
      if (len < MIN_B || er >= 0) begin
        expect_drop("rnd", 0);
      end else begin
        check_frame("rnd");
        ack_desc("rnd");
      end
    end

    chk("desc_stable", desc_glitch, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
